// File: rtl/aes_pkg.sv
// AES-128 shared definitions: byte type and the SubBytes tables.
// Used by SubBytes, the key schedule and MixColumns.
package aes_pkg;

    typedef logic [7:0]        aes_byte_t;
    typedef logic [0:255][7:0] sbox_tbl_t;

    // Row r holds S(16r) .. S(16r+15); index 0 is the leftmost byte.
    localparam sbox_tbl_t SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic sbox_tbl_t invert_tbl(input sbox_tbl_t t);
        sbox_tbl_t r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            r[t[i]] = 8'(i);
        end
        return r;
    endfunction

    localparam sbox_tbl_t SBOX_INV = invert_tbl(SBOX_FWD);

    function automatic aes_byte_t sbox_sub(input aes_byte_t b, input logic inv);
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/sbox_byte.sv
// Single-byte S-box lookup, combinational.
// Without INVERSE_EN only the forward table is built.
module sbox_byte
    import aes_pkg::*;
#(
    parameter int INVERSE_EN = 1
) (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

    if (INVERSE_EN != 0) begin : g_both
        assign out_byte = sbox_sub(in_byte, inv);
    end else begin : g_fwd
        logic unused_inv;
        assign unused_inv = inv;
        assign out_byte   = SBOX_FWD[in_byte];
    end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined SubBytes/InvSubBytes engine, LANES bytes per beat.
// Bubble-collapsing valid/ready pipeline, mode carried per beat.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int INVERSE_EN  = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               busy,
    output logic [CNT_W-1:0]   beat_cnt
);

    localparam int W    = 8 * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    logic         v  [PIPE_STAGES];
    logic         ld [PIPE_STAGES];
    logic [W-1:0] d  [PIPE_STAGES];
    logic         m  [PIPE_STAGES];
    logic [W-1:0] lookup;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_byte #(
            .INVERSE_EN(INVERSE_EN)
        ) u_sbox (
            .in_byte (d[0][8*i +: 8]),
            .inv     (m[0]),
            .out_byte(lookup[8*i +: 8])
        );
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic         src_v;
        logic [W-1:0] src_d;
        logic         src_m;

        if (s == 0) begin : g_src_in
            assign src_v = in_valid;
            assign src_d = in_data;
            assign src_m = in_inv && (INVERSE_EN != 0);
        end else if (s == 1) begin : g_src_lut
            assign src_v = v[0];
            assign src_d = lookup;
            assign src_m = m[0];
        end else begin : g_src_retime
            assign src_v = v[s-1];
            assign src_d = d[s-1];
            assign src_m = m[s-1];
        end

        // A stage frees up when it is empty or its content moves on.
        if (s == LAST) begin : g_ld_last
            assign ld[s] = !v[s] || out_ready;
        end else begin : g_ld_mid
            assign ld[s] = !v[s] || ld[s+1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v[s] <= 1'b0;
                d[s] <= '0;
                m[s] <= 1'b0;
            end else if (ld[s]) begin
                v[s] <= src_v;
                if (src_v) begin
                    d[s] <= src_d;
                    m[s] <= src_m;
                end
            end
        end
    end

    // Single-stage build: output is the live lookup, masked when empty.
    if (PIPE_STAGES == 1) begin : g_out_comb
        assign out_data = v[0] ? lookup : '0;
        assign out_inv  = v[0] && m[0];
    end else begin : g_out_reg
        assign out_data = d[LAST];
        assign out_inv  = m[LAST];
    end

    assign out_valid = v[LAST];
    assign in_ready  = ld[0];

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            busy = busy | v[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
